// File: rtl/keccak_squeezer_pkg.sv
// Shared constants, state encoding and rate lookup for the Keccak squeeze path.
package keccak_squeezer_pkg;

    localparam int KECCAK_W            = 64;
    localparam int KECCAK_STATE_W      = 1600;
    localparam int KECCAK_LEN_W        = 32;
    localparam int RATE_WORDS_SHAKE256 = 17;
    localparam int RATE_WORDS_SHAKE128 = 21;
    localparam int RATE_SHAKE128       = RATE_WORDS_SHAKE128 * KECCAK_W;

    typedef enum logic [1:0] {
        SQ_IDLE    = 2'd0,
        SQ_WAIT_ST = 2'd1,
        SQ_EMIT    = 2'd2,
        SQ_REQ     = 2'd3
    } squeeze_state_t;

    // Rate in 64-bit words for a mode code; 0 marks an unsupported mode.
    function automatic logic [4:0] rate_words(input logic [1:0] mode);
        case (mode)
            2'b11:   rate_words = 5'(RATE_WORDS_SHAKE256);
            2'b10:   rate_words = 5'(RATE_WORDS_SHAKE128);
            default: rate_words = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/keccak_squeezer.sv
// Squeeze end of the SHAKE core: streams rate lanes of the permuted state as
// 64-bit words and asks for another permutation when a block runs dry.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  IDLE     | waiting for start_i; len==0 jobs complete here directly
//  WAIT_ST  | state_ready_o high, waiting for a permuted state
//  EMIT     | presenting shreg_q[W-1:0], shifting one lane per handshake
//  REQ      | one-cycle perm_req_o, then back to WAIT_ST
module keccak_squeezer
    import keccak_squeezer_pkg::*;
#(
    parameter int W       = KECCAK_W,
    parameter int STATE_W = KECCAK_STATE_W,
    parameter int LEN_W   = KECCAK_LEN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [1:0]         mode_i,
    input  logic [LEN_W-1:0]   out_len_i,
    input  logic               state_valid_i,
    input  logic [STATE_W-1:0] state_i,
    output logic               state_ready_o,
    output logic               perm_req_o,
    output logic [W-1:0]       dout_o,
    output logic               dout_valid_o,
    input  logic               dout_ready_i,
    output logic               dout_last_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int SHREG_W = W * RATE_WORDS_SHAKE128;

    squeeze_state_t     state_q;
    logic [SHREG_W-1:0] shreg_q;
    logic [SHREG_W-1:0] load_d;
    logic [LEN_W-1:0]   remaining_q;
    logic [4:0]         word_cnt_q;
    logic [4:0]         rate_q;
    logic               done_q;
    logic [4:0]         start_rate;

    // Capacity lanes never reach the shift register.
    logic unused_capacity;
    assign unused_capacity = ^state_i[STATE_W-1:SHREG_W];

    assign start_rate = rate_words(mode_i);

    // Gather only the rate lanes of the current mode; the rest load as zero.
    always_comb begin
        load_d = '0;
        for (int k = 0; k < RATE_WORDS_SHAKE128; k++) begin
            if (k < int'(rate_q)) begin
                load_d[W*k +: W] = state_i[W*k +: W];
            end
        end
    end

    // Sequencer: job setup, state load, word streaming and re-permute requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SQ_IDLE;
            shreg_q     <= '0;
            remaining_q <= '0;
            word_cnt_q  <= '0;
            rate_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                SQ_IDLE: begin
                    if (start_i && (start_rate != 5'd0)) begin
                        if (out_len_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            rate_q      <= start_rate;
                            remaining_q <= out_len_i;
                            state_q     <= SQ_WAIT_ST;
                        end
                    end
                end
                SQ_WAIT_ST: begin
                    if (state_valid_i) begin
                        shreg_q    <= load_d;
                        word_cnt_q <= '0;
                        state_q    <= SQ_EMIT;
                    end
                end
                SQ_EMIT: begin
                    if (dout_ready_i) begin
                        shreg_q     <= shreg_q >> W;
                        word_cnt_q  <= word_cnt_q + 5'd1;
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= SQ_IDLE;
                        end else if ((word_cnt_q + 5'd1) == rate_q) begin
                            state_q <= SQ_REQ;
                        end
                    end
                end
                SQ_REQ: begin
                    state_q <= SQ_WAIT_ST;
                end
                default: begin
                    state_q <= SQ_IDLE;
                end
            endcase
        end
    end

    assign dout_o        = shreg_q[W-1:0];
    assign dout_valid_o  = (state_q == SQ_EMIT);
    assign dout_last_o   = (state_q == SQ_EMIT) && (remaining_q == LEN_W'(1));
    assign state_ready_o = (state_q == SQ_WAIT_ST);
    assign perm_req_o    = (state_q == SQ_REQ);
    assign busy_o        = (state_q != SQ_IDLE);
    assign done_o        = done_q;

endmodule

// File: tb/tb_keccak_squeezer.sv
// Randomized bench for keccak_squeezer against a block/lane output model.
module tb_keccak_squeezer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [1:0]    mode_i;
    logic [31:0]   out_len_i;
    logic          state_valid_i;
    logic [1599:0] state_i;
    logic          state_ready_o;
    logic          perm_req_o;
    logic [63:0]   dout_o;
    logic          dout_valid_o;
    logic          dout_ready_i;
    logic          dout_last_o;
    logic          busy_o;
    logic          done_o;

    int total = 0;
    int bad   = 0;

    // Expected permutation outputs: blocks[b][lane] is the state presented for block b.
    logic [63:0] blocks [4][25];

    always #5 clk = ~clk;

    keccak_squeezer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .mode_i        (mode_i),
        .out_len_i     (out_len_i),
        .state_valid_i (state_valid_i),
        .state_i       (state_i),
        .state_ready_o (state_ready_o),
        .perm_req_o    (perm_req_o),
        .dout_o        (dout_o),
        .dout_valid_o  (dout_valid_o),
        .dout_ready_i  (dout_ready_i),
        .dout_last_o   (dout_last_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic fill_blocks(input bit ident);
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 25; k++)
                blocks[b][k] = ident ? 64'(256 * b + k) : {$urandom, $urandom};
    endtask

    task automatic drive_state(input int blk, input bit real_state);
        for (int k = 0; k < 25; k++)
            state_i[64*k +: 64] = real_state ? blocks[blk][k] : {$urandom, $urandom};
    endtask

    // rdy_mode: 0 always ready, 1 toggle 1010.., 2 random.
    // rst_at >= 0 pulls reset while word rst_at is on the output.
    task automatic run_job(input logic [1:0] mode, input int len, input int rdy_mode,
                           input int rst_at, input bit noise);
        int          rate;
        int          idx;
        int          blk;
        int          perms;
        int          cyc;
        bit          done_seen;
        bit          exp_done;
        bit          pstall;
        bit          tog;
        bit          r;
        bit          v;
        logic [63:0] pdout;
        logic        plast;
        rate = (mode == 2'b11) ? 17 : 21;
        idx = 0; blk = 0; perms = 0; cyc = 0;
        done_seen = 0; exp_done = 0; pstall = 0; tog = 0;
        pdout = '0; plast = 0;

        start_i = 1'b1; mode_i = mode; out_len_i = 32'(len);
        @(posedge clk); #1;
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);

        while (!done_seen && cyc < 3000) begin
            cyc++;
            if (rst_at >= 0 && idx == rst_at && dout_valid_o) begin
                rst_n = 1'b0;
                #1;
                check("rst_dout_valid", dout_valid_o, 0);
                check("rst_dout", dout_o, 0);
                check("rst_last", dout_last_o, 0);
                check("rst_busy", busy_o, 0);
                check("rst_perm", perm_req_o, 0);
                check("rst_ready", state_ready_o, 0);
                @(posedge clk); #1;
                check("rst_no_done", done_o, 0);
                rst_n = 1'b1;
                state_valid_i = 1'b0;
                start_i = 1'b0;
                return;
            end

            check("done", done_o, exp_done);
            if (done_o) done_seen = 1;
            if (perm_req_o) begin
                perms++;
                if (blk < 3) blk++;
            end
            if (pstall) begin
                check("stall_valid", dout_valid_o, 1);
                check("stall_dout", dout_o, pdout);
                check("stall_last", dout_last_o, plast);
            end

            case (rdy_mode)
                0:       r = 1;
                1:       begin r = ~tog; tog = ~tog; end
                default: r = ($urandom_range(0, 1) == 1);
            endcase
            dout_ready_i = r;
            exp_done = 0;
            pstall = 0;
            if (dout_valid_o) begin
                if (idx >= len) begin
                    check("extra_word", dout_valid_o, 0);
                end else begin
                    if (r) begin
                        check("dout", dout_o, blocks[idx / rate][idx % rate]);
                        check("last", dout_last_o, 64'(idx == len - 1));
                        if (idx == len - 1) exp_done = 1;
                        idx++;
                    end else begin
                        pstall = 1;
                        pdout = dout_o;
                        plast = dout_last_o;
                    end
                end
            end

            if (state_ready_o) begin
                v = noise ? ($urandom_range(0, 3) != 0) : 1'b1;
                state_valid_i = v;
                drive_state(blk, v);
            end else begin
                state_valid_i = noise ? ($urandom_range(0, 1) == 1) : 1'b0;
                drive_state(blk, 1'b0);
            end

            start_i = noise && busy_o && ($urandom_range(0, 3) == 0);
            mode_i = 2'($urandom);
            out_len_i = 32'($urandom_range(0, 5));

            @(posedge clk); #1;
        end
        start_i = 1'b0;
        state_valid_i = 1'b0;
        check("job_finished", done_seen, 1);
        check("word_count", idx, len);
        check("perm_count", perms, (len + rate - 1) / rate - 1);
        check("busy_end", busy_o, 0);
        check("done_one_cycle", done_o, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start_i = 1'b0;
        mode_i = 2'b00;
        out_len_i = '0;
        state_valid_i = 1'b0;
        state_i = '0;
        dout_ready_i = 1'b0;
        #12;
        check("reset_busy", busy_o, 0);
        check("reset_valid", dout_valid_o, 0);
        check("reset_dout", dout_o, 0);
        check("reset_done", done_o, 0);
        check("reset_perm", perm_req_o, 0);
        check("reset_ready", state_ready_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full SHAKE128 block, no re-permute.
        fill_blocks(1);
        run_job(2'b10, 21, 0, -1, 0);

        // SHAKE256 crossing one block boundary.
        fill_blocks(1);
        run_job(2'b11, 20, 0, -1, 0);

        // Back-pressure with alternating ready.
        fill_blocks(0);
        run_job(2'b11, 3, 1, -1, 0);

        // Zero-length job.
        start_i = 1'b1; mode_i = 2'b11; out_len_i = '0;
        @(posedge clk); #1;
        start_i = 1'b0;
        check("len0_done", done_o, 1);
        check("len0_busy", busy_o, 0);
        check("len0_valid", dout_valid_o, 0);
        @(posedge clk); #1;
        check("len0_done_pulse", done_o, 0);
        check("len0_valid2", dout_valid_o, 0);

        // Unsupported mode is ignored.
        start_i = 1'b1; mode_i = 2'b01; out_len_i = 32'd5;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("badmode_busy", busy_o, 0);
            check("badmode_done", done_o, 0);
            check("badmode_ready", state_ready_o, 0);
            @(posedge clk); #1;
        end

        // Reset in the middle of a stream, then a clean job.
        fill_blocks(0);
        run_job(2'b11, 10, 0, 5, 0);
        fill_blocks(0);
        run_job(2'b10, 8, 0, -1, 0);

        // Spurious start/state_valid while streaming.
        fill_blocks(0);
        run_job(2'b10, 30, 0, -1, 1);

        // Random jobs.
        for (int j = 0; j < 12; j++) begin
            fill_blocks(0);
            run_job($urandom_range(0, 1) ? 2'b11 : 2'b10, $urandom_range(1, 60), 2, -1, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
